// File: rtl/kb_program_loader.sv
// PS/2 Set-2 keyboard program loader: assembles typed hex digits into 32-bit words and writes
// them to instruction memory while holding the CPU. Optional XOR checksum port: KB_LOADER_CHECKSUM_EN.
module kb_program_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned MAX_WORDS = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [7:0]  received_data,
  input  logic        received_data_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_we,
  output logic        cpu_hold,
  output logic [15:0] word_count,
  output logic [3:0]  nibble_count,
  output logic        err
`ifdef KB_LOADER_CHECKSUM_EN
  ,
  output logic [31:0] checksum
`endif
);

  typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

  localparam logic [7:0]  KEY_BREAK = 8'hF0;
  localparam logic [7:0]  KEY_EXT   = 8'hE0;
  localparam logic [7:0]  KEY_LOAD  = 8'h4B;
  localparam logic [7:0]  KEY_ENTER = 8'h5A;
  localparam logic [7:0]  KEY_BKSP  = 8'h66;
  localparam logic [7:0]  KEY_ESC   = 8'h76;
  localparam logic [15:0] MAX_W     = 16'(MAX_WORDS);
  localparam logic [31:0] STEP      = 32'(ADDR_STEP);

  state_t      state;
  logic [31:0] shift;
  logic        brk_pending;
  logic        ext_pending;
  logic        is_digit;
  logic [3:0]  digit;
  logic [15:0] word_count_next;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    is_digit = 1'b1;
    digit    = 4'h0;
    case (received_data)
      8'h45: digit = 4'h0;
      8'h16: digit = 4'h1;
      8'h1E: digit = 4'h2;
      8'h26: digit = 4'h3;
      8'h25: digit = 4'h4;
      8'h2E: digit = 4'h5;
      8'h36: digit = 4'h6;
      8'h3D: digit = 4'h7;
      8'h3E: digit = 4'h8;
      8'h46: digit = 4'h9;
      8'h1C: digit = 4'hA;
      8'h32: digit = 4'hB;
      8'h21: digit = 4'hC;
      8'h23: digit = 4'hD;
      8'h24: digit = 4'hE;
      8'h2B: digit = 4'hF;
      default: is_digit = 1'b0;
    endcase
  end

  // Saturates so the count can never wrap past MAX_WORDS.
  assign word_count_next = (word_count == MAX_W) ? word_count : word_count + 16'd1;

  // NOTE: sequential state uses non-blocking assignments only, so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      mem_addr     <= BASE_ADDR;
      mem_data     <= '0;
      mem_we       <= 1'b0;
      cpu_hold     <= 1'b0;
      word_count   <= '0;
      nibble_count <= '0;
      err          <= 1'b0;
      shift        <= '0;
      brk_pending  <= 1'b0;
      ext_pending  <= 1'b0;
`ifdef KB_LOADER_CHECKSUM_EN
      checksum     <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      err    <= 1'b0;
      if (received_data_en) begin
        if (received_data == KEY_BREAK) begin
          brk_pending <= 1'b1;
        end else if (received_data == KEY_EXT) begin
          ext_pending <= 1'b1;
        end else if (brk_pending) begin
          // Released key: swallow it so break codes never act.
          brk_pending <= 1'b0;
          ext_pending <= 1'b0;
        end else begin
          ext_pending <= 1'b0;
          case (state)
            IDLE: begin
              if (received_data == KEY_LOAD) begin
                state        <= COLLECT;
                cpu_hold     <= 1'b1;
                word_count   <= '0;
                shift        <= '0;
                nibble_count <= '0;
                mem_addr     <= BASE_ADDR;
`ifdef KB_LOADER_CHECKSUM_EN
                checksum     <= '0;
`endif
              end
            end
            COLLECT: begin
              if (is_digit) begin
                if (nibble_count < 4'd8) begin
                  shift        <= {shift[27:0], digit};
                  nibble_count <= nibble_count + 4'd1;
                end else begin
                  err <= 1'b1;
                end
              end else if (received_data == KEY_ENTER) begin
                if (nibble_count != 4'd0) begin
                  mem_we       <= 1'b1;
                  mem_data     <= shift;
                  mem_addr     <= BASE_ADDR + 32'(word_count) * STEP;
                  word_count   <= word_count_next;
                  shift        <= '0;
                  nibble_count <= '0;
`ifdef KB_LOADER_CHECKSUM_EN
                  checksum     <= checksum ^ shift;
`endif
                  if (word_count_next == MAX_W) state <= FULL;
                end else begin
                  err <= 1'b1;
                end
              end else if (received_data == KEY_BKSP) begin
                shift        <= '0;
                nibble_count <= '0;
              end else if (received_data == KEY_ESC) begin
                state        <= IDLE;
                cpu_hold     <= 1'b0;
                shift        <= '0;
                nibble_count <= '0;
              end else begin
                err <= 1'b1;
              end
            end
            FULL: begin
              if (received_data == KEY_ESC) begin
                state    <= IDLE;
                cpu_hold <= 1'b0;
              end else begin
                err <= 1'b1;
              end
            end
            default: begin
              state    <= IDLE;
              cpu_hold <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
